reg_wb_arbiter: RTL and testbench

- Write side of the register file interface. Takes results from two producers, ALU (single-cycle) and LSU (load data), over valid/ready handshakes.
- Arbitrates them onto the single write port (REG_write_1, REG_address_wr, REG_data_wb_in1) through one output register.
- Keeps a pending-write scoreboard so the decode stage can detect RAW hazards against in-flight destinations.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/reg_wb_arbiter_scoreboard.sv | 48 ++++
 rtl/reg_wb_arbiter.sv | 116 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file types and constants for the write-back path.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One write-back request as offered by a producer
    typedef struct packed {
        reg_addr_t             rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-write busy bitmap. One set port (issue), one clear port (write-back),
// two combinational read ports. Set wins over clear on the same register;
// register 0 is never busy.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              SYS_reset_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Apply clear first so a same-register set overrides it; pin x0 low
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (set_en)
            busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Bitmap register
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Reads see only registered state: no same-cycle bypass
    assign rd1_busy = busy[rd1_addr];
    assign rd2_busy = busy[rd2_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: LSU-priority grant with ALU starvation
// guard, registered single write port, and pending-write scoreboard.
// Optional commit counters are built when WB_STATS_EN is defined.
module reg_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W       = REG_DATA_W,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              SYS_reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
`ifdef WB_STATS_EN
    output logic [31:0]       alu_commit_cnt,
    output logic [31:0]       lsu_commit_cnt,
`endif
    output logic              REG_write_1,
    output logic [ADDR_W-1:0] REG_address_wr,
    output logic [DATA_W-1:0] REG_data_wb_in1
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          alu_forced;
    logic          alu_xfer;
    logic          lsu_xfer;
    logic          any_xfer;
    wb_req_t       alu_req;
    wb_req_t       lsu_req;
    wb_req_t       win_req;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign lsu_req = '{rd: lsu_rd, data: lsu_data};

    // Grant is purely a function of the offers and the starve count;
    // the register file never backpressures.
    assign alu_forced = (starve_cnt == STARVE_MAX);
    assign lsu_ready  = lsu_valid & ~alu_forced;
    assign alu_ready  = alu_valid & (~lsu_valid | alu_forced);
    assign lsu_xfer   = lsu_ready;
    assign alu_xfer   = alu_ready;
    assign any_xfer   = lsu_xfer | alu_xfer;
    assign win_req    = lsu_xfer ? lsu_req : alu_req;

    // Count consecutive ALU losses; any ALU win or idle ALU restarts it
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n)
            starve_cnt <= '0;
        else if (alu_valid && lsu_xfer)
            starve_cnt <= alu_forced ? starve_cnt : starve_cnt + 1'b1;
        else
            starve_cnt <= '0;
    end

    // Output register: x0 transfers load addr/data but never assert the write
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            REG_write_1     <= 1'b0;
            REG_address_wr  <= '0;
            REG_data_wb_in1 <= '0;
        end else if (any_xfer) begin
            REG_write_1     <= (win_req.rd != '0);
            REG_address_wr  <= win_req.rd;
            REG_data_wb_in1 <= win_req.data;
        end else begin
            REG_write_1     <= 1'b0;
        end
    end

`ifdef WB_STATS_EN
    // Committed (non-x0) writes per source, free-running with wrap
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            alu_commit_cnt <= '0;
            lsu_commit_cnt <= '0;
        end else begin
            if (alu_xfer && alu_rd != '0)
                alu_commit_cnt <= alu_commit_cnt + 32'd1;
            if (lsu_xfer && lsu_rd != '0)
                lsu_commit_cnt <= lsu_commit_cnt + 32'd1;
        end
    end
`endif

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .SYS_reset_n (SYS_reset_n),
        .set_en      (issue_valid && issue_rd != '0),
        .set_addr    (issue_rd),
        .clr_en      (any_xfer),
        .clr_addr    (win_req.rd),
        .rd1_addr    (rs1_addr),
        .rd2_addr    (rs2_addr),
        .rd1_busy    (rs1_busy),
        .rd2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: hand-written reset sequence, then a
// table of per-cycle vectors checking grants, busy reads and the write port.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        SYS_reset_n = 1'b0;
    logic        alu_valid = 0, lsu_valid = 0, issue_valid = 0;
    logic        alu_ready, lsu_ready, rs1_busy, rs2_busy;
    logic [4:0]  alu_rd = 0, lsu_rd = 0, issue_rd = 0, rs1_addr = 0, rs2_addr = 0;
    logic [31:0] alu_data = 0, lsu_data = 0;
    logic        REG_write_1;
    logic [4:0]  REG_address_wr;
    logic [31:0] REG_data_wb_in1;
`ifdef WB_STATS_EN
    logic [31:0] alu_commit_cnt, lsu_commit_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk             (clk),
        .SYS_reset_n     (SYS_reset_n),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
`ifdef WB_STATS_EN
        .alu_commit_cnt  (alu_commit_cnt),
        .lsu_commit_cnt  (lsu_commit_cnt),
`endif
        .REG_write_1     (REG_write_1),
        .REG_address_wr  (REG_address_wr),
        .REG_data_wb_in1 (REG_data_wb_in1)
    );

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] adat;
        logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
        logic        iv;  logic [4:0] ird;
        logic [4:0]  rs1; logic [4:0] rs2;
        // expected combinational outputs before the edge
        logic        e_ar, e_lr, e_b1, e_b2;
        // expected registered outputs after the edge
        logic        e_we; logic [4:0] e_addr; logic [31:0] e_data;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic e_ar, input logic e_lr, input logic e_b1, input logic e_b2,
        input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        // ---- table: starts from a clean post-reset state ----
        //           av ard  adat          lv lrd ldat   iv ird rs1 rs2  ar lr b1 b2  we addr data
        vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0,  5,  0,  1, 0, 0, 0,  1, 5, 32'hDEADBEEF));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  0,  0,  0, 0, 0, 0,  0, 5, 32'hDEADBEEF));
        vt.push_back(mk(1, 4, 32'h22,       1, 3, 32'h11, 0, 0,  0,  0,  0, 1, 0, 0,  1, 3, 32'h11));
        vt.push_back(mk(1, 4, 32'h22,       0, 0, 0,      0, 0,  0,  0,  1, 0, 0, 0,  1, 4, 32'h22));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  0,  0,  0, 0, 0, 0,  0, 4, 32'h22));
        vt.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,      0, 0,  0,  0,  1, 0, 0, 0,  0, 0, 32'hFFFFFFFF));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      1, 7,  7,  7,  0, 0, 0, 0,  0, 0, 32'hFFFFFFFF));
        vt.push_back(mk(0, 0, 0,            1, 7, 32'h77, 1, 7,  7,  0,  0, 1, 1, 0,  1, 7, 32'h77));
        vt.push_back(mk(1, 7, 32'h70,       0, 0, 0,      0, 0,  7,  0,  1, 0, 1, 0,  1, 7, 32'h70));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  7,  7,  0, 0, 0, 0,  0, 7, 32'h70));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      1, 12, 12, 0,  0, 0, 0, 0,  0, 7, 32'h70));
        vt.push_back(mk(0, 0, 0,            1, 12, 32'hC, 1, 13, 12, 13, 0, 1, 1, 0,  1, 12, 32'hC));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  12, 13, 0, 0, 0, 1,  0, 12, 32'hC));
        // starvation: both valid every cycle, ALU forced through every 4th
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++)
                vt.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 13, 0, 0, 1, 1, 0, 1, 2, 32'hB2));
            vt.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 13, 0, 1, 0, 1, 0, 1, 1, 32'hA1));
        end
        vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  0,  0,  0, 0, 0, 0,  0, 1, 32'hA1));

        // ---- reset state ----
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",   32'(REG_write_1), 0);
        check("rst_addr", 32'(REG_address_wr), 0);
        check("rst_data", REG_data_wb_in1, 0);
        check("rst_rdy",  {30'd0, alu_ready, lsu_ready}, 0);
        @(negedge clk);
        SYS_reset_n = 1'b1;

        // ---- async reset hitting live state and an in-flight offer ----
        @(posedge clk); #1;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        issue_valid = 1; issue_rd = 20; rs1_addr = 20;
        @(posedge clk); #1;
        check("pre_rst_we",   32'(REG_write_1), 1);
        check("pre_rst_busy", 32'(rs1_busy), 1);
        issue_valid = 0; alu_rd = 6; alu_data = 32'h66;
        #2 SYS_reset_n = 1'b0;
        #1;
        check("async_rst_we",   32'(REG_write_1), 0);
        check("async_rst_addr", 32'(REG_address_wr), 0);
        check("async_rst_data", REG_data_wb_in1, 0);
        check("async_rst_busy", 32'(rs1_busy), 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        SYS_reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_we",   32'(REG_write_1), 0);
        check("post_rst_data", REG_data_wb_in1, 0);
`ifdef WB_STATS_EN
        check("post_rst_alu_cnt", alu_commit_cnt, 0);
`endif

        // ---- table-driven cycles ----
        for (int i = 0; i < vt.size(); i++) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adat;
            lsu_valid = vt[i].lv; lsu_rd = vt[i].lrd; lsu_data = vt[i].ldat;
            issue_valid = vt[i].iv; issue_rd = vt[i].ird;
            rs1_addr = vt[i].rs1; rs2_addr = vt[i].rs2;
            @(negedge clk);
            check($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vt[i].e_ar));
            check($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(vt[i].e_lr));
            check($sformatf("v%0d_rs1_busy", i),  32'(rs1_busy),  32'(vt[i].e_b1));
            check($sformatf("v%0d_rs2_busy", i),  32'(rs2_busy),  32'(vt[i].e_b2));
            @(posedge clk); #1;
            check($sformatf("v%0d_we", i),   32'(REG_write_1),    32'(vt[i].e_we));
            check($sformatf("v%0d_addr", i), 32'(REG_address_wr), 32'(vt[i].e_addr));
            check($sformatf("v%0d_data", i), REG_data_wb_in1,     vt[i].e_data);
        end

        // x0 is never busy even after an issue to it
        issue_valid = 1; issue_rd = 0; rs1_addr = 0;
        @(posedge clk); #1;
        idle_inputs();
        check("x0_busy", 32'(rs1_busy), 0);

`ifdef WB_STATS_EN
        // ALU non-x0 commits: rd5, rd4, rd7, and two forced rd1 wins
        check("alu_commit_cnt", alu_commit_cnt, 5);
        // LSU commits: rd3, rd7, rd12, six starvation-phase rd2
        check("lsu_commit_cnt", lsu_commit_cnt, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
